// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Command-side initiator for a combinational 32-bit ALU.
//               Handles single-cycle ops and a shift-add unsigned multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic [3:0]   cmd_tag,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [N-1:0] alu_result,
    input  logic         alu_v,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_z,
    output logic         rsp_n,
    output logic         rsp_v,
    output logic [3:0]   rsp_tag
);

    localparam int CNT_W = $clog2(N + 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_EXEC = 2'd1;
    localparam logic [1:0] C_MUL  = 2'd2;
    localparam logic [1:0] C_RESP = 2'd3;

    localparam logic [2:0] C_OP_ADD = 3'd0;
    localparam logic [2:0] C_OP_SUB = 3'd1;
    localparam logic [2:0] C_OP_AND = 3'd2;
    localparam logic [2:0] C_OP_OR  = 3'd3;
    localparam logic [2:0] C_OP_SHR = 3'd4;
    localparam logic [2:0] C_OP_SHL = 3'd5;
    localparam logic [2:0] C_OP_MOV = 3'd6;
    localparam logic [2:0] C_OP_MUL = 3'd7;

    localparam logic [3:0] C_SEL_IDLE = 4'b0000;
    localparam logic [3:0] C_SEL_ADD  = 4'b0001;
    localparam logic [3:0] C_SEL_SUB  = 4'b0010;
    localparam logic [3:0] C_SEL_SHR  = 4'b0011;
    localparam logic [3:0] C_SEL_SHL  = 4'b0100;
    localparam logic [3:0] C_SEL_AND  = 4'b0101;
    localparam logic [3:0] C_SEL_OR   = 4'b0110;
    localparam logic [3:0] C_SEL_MOV  = 4'b0111;

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [3:0]       r_tag;
    logic [N-1:0]     r_acc;
    logic [N-1:0]     r_m;
    logic [N-1:0]     r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_v_sticky;

    logic             w_mul_done;
    logic [3:0]       w_exec_sel;

    assign cmd_ready  = (r_state == C_IDLE);
    assign rsp_valid  = (r_state == C_RESP);
    assign w_mul_done = (r_q == '0) || (r_cnt == CNT_W'(N));

    always_comb begin
        w_exec_sel = C_SEL_IDLE;
        case (r_op)
            C_OP_ADD: w_exec_sel = C_SEL_ADD;
            C_OP_SUB: w_exec_sel = C_SEL_SUB;
            C_OP_AND: w_exec_sel = C_SEL_AND;
            C_OP_OR:  w_exec_sel = C_SEL_OR;
            C_OP_SHR: w_exec_sel = C_SEL_SHR;
            C_OP_SHL: w_exec_sel = C_SEL_SHL;
            C_OP_MOV: w_exec_sel = C_SEL_MOV;
            default:  w_exec_sel = C_SEL_IDLE;
        endcase
    end

    // ALU is only driven while it does useful work; otherwise it sees zeros.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = C_SEL_IDLE;
        if (r_state == C_EXEC) begin
            alu_a   = r_a;
            alu_b   = r_b;
            alu_sel = w_exec_sel;
        end else if (r_state == C_MUL && !w_mul_done) begin
            alu_a   = r_acc;
            alu_b   = r_m;
            alu_sel = C_SEL_ADD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= C_IDLE;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_tag      <= '0;
            r_acc      <= '0;
            r_m        <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_v_sticky <= 1'b0;
            rsp_result <= '0;
            rsp_z      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_tag    <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_a   <= cmd_a;
                        r_b   <= cmd_b;
                        r_tag <= cmd_tag;
                        if (cmd_op == C_OP_MUL) begin
                            r_acc      <= '0;
                            r_m        <= cmd_a;
                            r_q        <= cmd_b;
                            r_cnt      <= '0;
                            r_v_sticky <= 1'b0;
                            r_state    <= C_MUL;
                        end else begin
                            r_state <= C_EXEC;
                        end
                    end
                end
                C_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_z      <= (alu_result == '0);
                    rsp_n      <= alu_result[N-1];
                    rsp_v      <= ((r_op == C_OP_ADD) || (r_op == C_OP_SUB)) ? alu_v : 1'b0;
                    rsp_tag    <= r_tag;
                    r_state    <= C_RESP;
                end
                C_MUL: begin
                    if (w_mul_done) begin
                        rsp_result <= r_acc;
                        rsp_z      <= (r_acc == '0);
                        rsp_n      <= r_acc[N-1];
                        rsp_v      <= r_v_sticky;
                        rsp_tag    <= r_tag;
                        r_state    <= C_RESP;
                    end else begin
                        if (r_q[0]) begin
                            r_acc      <= alu_result;
                            r_v_sticky <= r_v_sticky | alu_v;
                        end
                        r_m   <= r_m << 1;
                        r_q   <= r_q >> 1;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                C_RESP: begin
                    if (rsp_ready) begin
                        r_state <= C_IDLE;
                    end
                end
                default: r_state <= C_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench: ALU model plus arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [3:0]  cmd_tag = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;
    logic        alu_v;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_z, rsp_n, rsp_v;
    logic [3:0]  rsp_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_v(rsp_v), .rsp_tag(rsp_tag)
    );

    // Combinational ALU attached to the sequencer
    always_comb begin
        alu_result = '0;
        alu_v      = 1'b0;
        case (alu_sel)
            4'd1: begin
                alu_result = alu_a + alu_b;
                alu_v = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'd2: begin
                alu_result = alu_a - alu_b;
                alu_v = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'd3: alu_result = (alu_b >= 32) ? 32'd0 : alu_a >> alu_b;
            4'd4: alu_result = (alu_b >= 32) ? 32'd0 : alu_a << alu_b;
            4'd5: alu_result = alu_a & alu_b;
            4'd6: alu_result = alu_a | alu_b;
            4'd7: alu_result = alu_b;
            default: ;
        endcase
    end

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic z, output logic n,
                                  output logic v, output int lat);
        logic [31:0] acc, part, s;
        int p;
        v   = 1'b0;
        lat = 2;
        case (op)
            3'd0: begin res = a + b; v = (a[31] == b[31]) && (res[31] != a[31]); end
            3'd1: begin res = a - b; v = (a[31] != b[31]) && (res[31] != a[31]); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = (b >= 32) ? 32'd0 : a >> b;
            3'd5: res = (b >= 32) ? 32'd0 : a << b;
            3'd6: res = b;
            default: begin
                res = 32'(64'(a) * 64'(b));
                acc = '0;
                p   = 0;
                for (int i = 0; i < 32; i++) begin
                    if (b[i]) begin
                        part = a << i;
                        s    = acc + part;
                        if ((acc[31] == part[31]) && (s[31] != acc[31])) v = 1'b1;
                        acc = s;
                        p   = i + 1;
                    end
                end
                lat = 2 + p;
            end
        endcase
        z = (res == 32'd0);
        n = res[31];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the accept cycle; returns at the first negedge with rsp_valid.
    task automatic wait_rsp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag);
        logic [31:0] er;
        logic ez, en, ev;
        int elat, lat;
        model(op, a, b, er, ez, en, ev, elat);
        lat = 0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) lat = i;
        end
        chk($sformatf("latency op%0d", op), 32'(lat), 32'(elat));
        if (lat != 0) begin
            chk($sformatf("result op%0d", op), rsp_result, er);
            chk("flags z/n/v", {29'd0, rsp_z, rsp_n, rsp_v}, {29'd0, ez, en, ev});
            chk("tag", {28'd0, rsp_tag}, {28'd0, tag});
            chk("cmd_ready in RESP", {31'd0, cmd_ready}, 32'd0);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
        int k;
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready before accept", {31'd0, cmd_ready}, 32'd1);
        wait_rsp(op, a, b, tag);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_valid after handshake", {31'd0, rsp_valid}, 32'd0);
        chk("cmd_ready after handshake", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_result", rsp_result, 32'd0);
        chk("reset alu_sel", {28'd0, alu_sel}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready after reset", {31'd0, cmd_ready}, 32'd1);
        chk("reset rsp flags/tag", {25'd0, rsp_z, rsp_n, rsp_v, rsp_tag}, 32'd0);
        chk("reset alu_a|alu_b", alu_a | alu_b, 32'd0);

        // Directed operations
        issue(3'd0, 32'h7FFF_FFFF, 32'd1, 4'd3);         finish_rsp();
        issue(3'd1, 32'd5, 32'd5, 4'd1);                 finish_rsp();
        issue(3'd2, 32'h0000_F0F0, 32'h0000_0FF0, 4'd2); finish_rsp();
        issue(3'd4, 32'h8000_0000, 32'd31, 4'd4);        finish_rsp();
        issue(3'd5, 32'd1, 32'd32, 4'd5);                finish_rsp();
        issue(3'd6, 32'd0, 32'hDEAD_BEEF, 4'd6);         finish_rsp();
        issue(3'd7, 32'd7, 32'd6, 4'd7);                 finish_rsp();
        issue(3'd7, 32'd9, 32'd0, 4'd8);                 finish_rsp();
        issue(3'd7, 32'd1, 32'h8000_0000, 4'd9);         finish_rsp();
        issue(3'd7, 32'h4000_0000, 32'd3, 4'd10);        finish_rsp();

        // Back-pressure with a second command waiting
        rsp_ready = 1'b0;
        issue(3'd3, 32'h0000_1234, 32'h00FF_0000, 4'd5);
        cmd_op = 3'd0; cmd_a = 32'd100; cmd_b = 32'd23; cmd_tag = 4'd9; cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("hold rsp_result", rsp_result, 32'h00FF_1234);
            chk("hold rsp_tag", {28'd0, rsp_tag}, 32'd5);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp rsp_valid dropped", {31'd0, rsp_valid}, 32'd0);
        chk("bp cmd_ready back", {31'd0, cmd_ready}, 32'd1);
        wait_rsp(3'd0, 32'd100, 32'd23, 4'd9);
        finish_rsp();

        // Reset during MUL iteration 10
        @(negedge clk);
        cmd_op = 3'd7; cmd_a = 32'd3; cmd_b = 32'hFFFF_FFFF; cmd_tag = 4'd7; cmd_valid = 1'b1;
        chk("mul accept ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async alu_sel", {28'd0, alu_sel}, 32'd0);
        chk("async alu_a|alu_b", alu_a | alu_b, 32'd0);
        chk("async rsp_result", rsp_result, 32'd0);
        chk("async rsp flags/tag", {25'd0, rsp_z, rsp_n, rsp_v, rsp_tag}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after mid reset", {31'd0, cmd_ready}, 32'd1);
        chk("no stale rsp", {31'd0, rsp_valid}, 32'd0);
        issue(3'd1, 32'd10, 32'd3, 4'd2); finish_rsp();

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (op == 3'd4 || op == 3'd5) b = 32'($urandom_range(0, 40));
            if (op == 3'd7 && $urandom_range(0, 1) == 0) b = 32'($urandom_range(0, 1000));
            issue(op, a, b, 4'($urandom_range(0, 15)));
            finish_rsp();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
